// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment driver with per-digit blanking,
// decimal points, anti-ghosting blank slots and frame-synchronous updates.
module seven_seg_scanner #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIV_CYCLES   = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int unsigned PW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DW = 4 * NUM_DIGITS;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0] pend_en_q, pend_en_d;
    logic [DW-1:0]         act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] act_en_q, act_en_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  presc_wrap;
    logic                  frame_end;
    logic                  blank;
    logic                  show;
    logic [3:0]            nib;
    logic                  en_k;
    logic                  dp_k;
    logic [NUM_DIGITS-1:0] sel;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Slot counters and double buffer; a load on the frame boundary goes straight to active.
    always_comb begin
        presc_wrap = (presc_q == PW'(DIV_CYCLES - 1));
        frame_end  = presc_wrap && (idx_q == IW'(NUM_DIGITS - 1));

        presc_d = presc_wrap ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_wrap) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end

        pend_dig_d = pend_dig_q;
        pend_dp_d  = pend_dp_q;
        pend_en_d  = pend_en_q;
        if (load) begin
            pend_dig_d = digits_in;
            pend_dp_d  = dp_in;
            pend_en_d  = digit_en;
        end

        act_dig_d = act_dig_q;
        act_dp_d  = act_dp_q;
        act_en_d  = act_en_q;
        if (frame_end) begin
            act_dig_d = pend_dig_d;
            act_dp_d  = pend_dp_d;
            act_en_d  = pend_en_d;
        end
    end

    // Pin decode from the current slot; registered so pins lag the counters by one cycle.
    always_comb begin
        blank = (presc_q < PW'(BLANK_CYCLES));
        nib   = 4'h0;
        en_k  = 1'b0;
        dp_k  = 1'b0;
        sel   = '0;
        for (int j = 0; j < int'(NUM_DIGITS); j++) begin
            if (idx_q == IW'(int'(NUM_DIGITS) - 1 - j)) begin
                nib    = act_dig_q[4*j +: 4];
                en_k   = act_en_q[j];
                dp_k   = act_dp_q[j];
                sel[j] = 1'b1;
            end
        end
        show = en_k && !blank;

        anode_d      = show ? ~sel : '1;
        seg_d        = show ? hex7(nib) : 7'h7F;
        dp_d         = show ? ~dp_k : 1'b1;
        frame_tick_d = frame_end;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            act_dig_q    <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            anode_q      <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            act_dig_q    <= act_dig_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anode      = anode_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule
